// File: rtl/exec_alu_if.sv
// Handshake/data bundle between the issue logic, the execute ALU and the downstream stage.
interface exec_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [4:0]       aluop;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall_in;
  logic             flush;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, aluop, op_a, op_b, stall_in, flush,
    input  busy, out_valid, result, zero
  );

  modport slave (
    input  in_valid, aluop, op_a, op_b, stall_in, flush,
    output busy, out_valid, result, zero
  );
endinterface

// File: rtl/exec_alu.sv
// Execute-stage ALU: single-cycle ADD/SUB/MOV/JUMP, iterative shift-add MUL,
// registered result and zero flag held under downstream stall.
module exec_alu #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 4
) (
  input logic        clk,
  input logic        reset,
  exec_alu_if.slave  bus
);

  localparam int N     = WIDTH / MUL_BPC;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [4:0] ALUOP_ADD  = 5'd0;
  localparam logic [4:0] ALUOP_SUB  = 5'd1;
  localparam logic [4:0] ALUOP_MOV  = 5'd2;
  localparam logic [4:0] ALUOP_JUMP = 5'd3;
  localparam logic [4:0] ALUOP_MUL  = 5'd4;

  logic [0:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0] mcand_q,    mcand_d;
  logic [WIDTH-1:0] mplier_q,   mplier_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             zero_q,     zero_d;
  logic             outValid_q, outValid_d;

  logic             busy;
  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] singleResult;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] accSum;

  assign busy    = (state_q == ST_MUL) | (outValid_q & bus.stall_in);
  assign accept  = bus.in_valid & ~busy & ~bus.flush;
  assign consume = outValid_q & ~bus.stall_in;

  assign bus.busy      = busy;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

  // One radix-2^MUL_BPC digit of the multiplier per iteration; only the low WIDTH bits matter.
  assign partial = mcand_q * {{(WIDTH-MUL_BPC){1'b0}}, mplier_q[MUL_BPC-1:0]};
  assign accSum  = acc_q + partial;

  always_comb begin
    singleResult = '0;
    case (bus.aluop)
      ALUOP_ADD:  singleResult = bus.op_a + bus.op_b;
      ALUOP_SUB:  singleResult = bus.op_a - bus.op_b;
      ALUOP_MOV:  singleResult = bus.op_b;
      ALUOP_JUMP: singleResult = bus.op_a;
      default:    singleResult = '0;
    endcase
  end

  // Flush wins over a running MUL and over any same-cycle issue; result/zero are left as they were.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    result_d   = result_q;
    zero_d     = zero_q;
    outValid_d = outValid_q;

    if (bus.flush) begin
      state_d    = ST_IDLE;
      outValid_d = 1'b0;
    end else if (state_q == ST_MUL) begin
      acc_d    = accSum;
      mcand_d  = mcand_q << MUL_BPC;
      mplier_d = mplier_q >> MUL_BPC;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        result_d   = accSum;
        zero_d     = (accSum == '0);
        outValid_d = 1'b1;
        state_d    = ST_IDLE;
      end
    end else if (accept) begin
      if (bus.aluop == ALUOP_MUL) begin
        state_d    = ST_MUL;
        cnt_d      = CNT_W'(N);
        acc_d      = '0;
        mcand_d    = bus.op_a;
        mplier_d   = bus.op_b;
        outValid_d = 1'b0;
      end else begin
        result_d   = singleResult;
        zero_d     = (singleResult == '0);
        outValid_d = 1'b1;
      end
    end else if (consume) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_exec_alu.sv
// Self-checking bench for exec_alu: directed vector table, hand-written stall/flush/reset
// sequences, and randomized operations checked against an arithmetic reference model.
module tb_exec_alu;

  localparam int WIDTH   = 32;
  localparam int MUL_BPC = 4;
  localparam int N       = WIDTH / MUL_BPC;

  localparam logic [4:0] ALUOP_ADD  = 5'd0;
  localparam logic [4:0] ALUOP_SUB  = 5'd1;
  localparam logic [4:0] ALUOP_MOV  = 5'd2;
  localparam logic [4:0] ALUOP_JUMP = 5'd3;
  localparam logic [4:0] ALUOP_MUL  = 5'd4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  exec_alu_if #(.WIDTH(WIDTH)) bus ();

  exec_alu #(.WIDTH(WIDTH), .MUL_BPC(MUL_BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expZero;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one edge; caller makes sure the ALU is not busy.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.aluop    = op;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat, output int busyCycles);
    lat        = 1;
    busyCycles = 0;
    while (!bus.out_valid && lat < 4 * N) begin
      if (bus.busy) busyCycles++;
      tick();
      lat++;
    end
  endtask

  function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (op)
      ALUOP_ADD:  return a + b;
      ALUOP_SUB:  return a - b;
      ALUOP_MOV:  return b;
      ALUOP_JUMP: return a;
      ALUOP_MUL:  return prod[31:0];
      default:    return 32'd0;
    endcase
  endfunction

  task automatic runVector(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expR, input logic expZ);
    int lat;
    int bc;
    applyStimulus(op, a, b);
    waitResult(lat, bc);
    checkOutput($sformatf("%s_valid", name), 32'(bus.out_valid), 32'd1);
    checkOutput($sformatf("%s_result", name), bus.result, expR);
    checkOutput($sformatf("%s_zero", name), 32'(bus.zero), 32'(expZ));
    checkOutput($sformatf("%s_latency", name), 32'(lat), (op == ALUOP_MUL) ? 32'(N + 1) : 32'd1);
    checkOutput($sformatf("%s_busycycles", name), 32'(bc), (op == ALUOP_MUL) ? 32'(N) : 32'd0);
  endtask

  task automatic checkNoPulse(input string name);
    int pulses;
    pulses = 0;
    repeat (2 * N) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    checkOutput(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          bc;

    bus.in_valid = 1'b0;
    bus.aluop    = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    reset        = 1'b1;
    repeat (2) tick();
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_result", bus.result, 32'd0);
    checkOutput("reset_zero", 32'(bus.zero), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();

    vecs.push_back('{"add_wrap",   ALUOP_ADD,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 1'b0});
    vecs.push_back('{"sub_eq",     ALUOP_SUB,  32'd5,         32'd5,         32'h0000_0000, 1'b1});
    vecs.push_back('{"sub_neg",    ALUOP_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{"mov",        ALUOP_MOV,  32'hDEAD_BEEF, 32'd9,         32'h0000_0009, 1'b0});
    vecs.push_back('{"jump",       ALUOP_JUMP, 32'h0000_0400, 32'h1234,      32'h0000_0400, 1'b0});
    vecs.push_back('{"unknown",    5'h1F,      32'd1,         32'd1,         32'h0000_0000, 1'b1});
    vecs.push_back('{"mul_shift",  ALUOP_MUL,  32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0});
    vecs.push_back('{"mul_ones",   ALUOP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    vecs.push_back('{"mul_zero",   ALUOP_MUL,  32'd0,         32'd5,         32'h0000_0000, 1'b1});
    vecs.push_back('{"mul_full",   ALUOP_MUL,  32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0});

    foreach (vecs[i])
      runVector(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expResult, vecs[i].expZero);
    tick();

    // Back-to-back single-cycle ops, one result per cycle.
    bus.in_valid = 1'b1; bus.aluop = ALUOP_ADD; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd2;
    tick();
    checkOutput("b2b_add_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("b2b_add_result", bus.result, 32'd1);
    checkOutput("b2b_add_zero", 32'(bus.zero), 32'd0);
    bus.aluop = ALUOP_SUB; bus.op_a = 32'd5; bus.op_b = 32'd5;
    tick();
    bus.in_valid = 1'b0;
    checkOutput("b2b_sub_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("b2b_sub_result", bus.result, 32'd0);
    checkOutput("b2b_sub_zero", 32'(bus.zero), 32'd1);
    tick();
    checkOutput("b2b_consumed", 32'(bus.out_valid), 32'd0);

    // Downstream stall holds the result and blocks the next op.
    bus.stall_in = 1'b1;
    applyStimulus(ALUOP_ADD, 32'd3, 32'd4);
    checkOutput("stall_add_result", bus.result, 32'd7);
    bus.in_valid = 1'b1; bus.aluop = ALUOP_MOV; bus.op_a = 32'd0; bus.op_b = 32'd9;
    #1;
    checkOutput("stall_busy_now", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall_hold%0d_result", i), bus.result, 32'd7);
      checkOutput($sformatf("stall_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("stall_hold%0d_busy", i), 32'(bus.busy), 32'd1);
    end
    bus.stall_in = 1'b0;
    #1;
    checkOutput("stall_release_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("stall_mov_result", bus.result, 32'd9);
    checkOutput("stall_mov_valid", 32'(bus.out_valid), 32'd1);
    tick();
    checkOutput("stall_mov_consumed", 32'(bus.out_valid), 32'd0);

    // Flush mid-MUL with a same-cycle op that must be ignored.
    applyStimulus(ALUOP_MUL, 32'h1234, 32'h5678);
    repeat (3) tick();
    checkOutput("flush_pre_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.aluop = ALUOP_ADD; bus.op_a = 32'd1; bus.op_b = 32'd1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_busy", 32'(bus.busy), 32'd0);
    checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_result_kept", bus.result, 32'd9);
    checkNoPulse("flush_no_pulse");

    // Reset mid-MUL.
    applyStimulus(ALUOP_MUL, 32'h1234, 32'h5678);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstmul_busy", 32'(bus.busy), 32'd0);
    checkOutput("rstmul_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstmul_result", bus.result, 32'd0);
    checkOutput("rstmul_zero", 32'(bus.zero), 32'd0);
    checkNoPulse("rstmul_no_pulse");

    // MUL completes while downstream is stalled.
    applyStimulus(ALUOP_MUL, 32'h1234_5678, 32'h10);
    bus.stall_in = 1'b1;
    waitResult(lat, bc);
    checkOutput("mulstall_latency", 32'(lat), 32'(N + 1));
    checkOutput("mulstall_result", bus.result, 32'h2345_6780);
    repeat (3) tick();
    checkOutput("mulstall_held_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mulstall_held_result", bus.result, 32'h2345_6780);
    checkOutput("mulstall_held_busy", 32'(bus.busy), 32'd1);
    bus.stall_in = 1'b0;
    tick();
    checkOutput("mulstall_consumed", 32'(bus.out_valid), 32'd0);

    // Randomized operations against the arithmetic reference model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = ALUOP_ADD;
        2, 3:    op = ALUOP_SUB;
        4:       op = ALUOP_MOV;
        5:       op = ALUOP_JUMP;
        6, 7, 8: op = ALUOP_MUL;
        default: op = 5'($urandom_range(5, 31));
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      runVector($sformatf("rand%0d_op%0d", i, op), op, a, b, refModel(op, a, b),
                refModel(op, a, b) == 32'd0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
